mvm_stream_loader: RTL and testbench
====================================

MVM_STREAM_LOADER -- requirements
Module: mvm_stream_loader

Interface
REQ-001 Parameter K, default 4: matrix dimension; frame = K*K matrix words (row-major) followed by K vector words.
REQ-002 Parameter B, default 8: data word width in bits.
REQ-003 Port clk  input  1: single clock; all state changes on rising edge.
REQ-004 Port reset  input  1: asynchronous, active-low reset.
REQ-005 Port s_data  input  B (signed): upstream word.
REQ-006 Port s_valid  input  1: upstream word valid.
REQ-007 Port s_ready  output  1: block accepts a word this cycle.
REQ-008 Port loadMatrix  output  1: one-cycle pulse to the MVM that opens matrix load.
REQ-009 Port loadVector  output  1: one-cycle pulse to the MVM that opens vector load.
REQ-010 Port start  output  1: one-cycle pulse to the MVM that starts computation.
REQ-011 Port data_out  output  B (signed): word driven to the MVM data_in.
REQ-012 Port done  input  1: MVM completion pulse.
REQ-013 Port busy  output  1: high in any state other than FILL.
REQ-014 Port err  output  1: sticky protocol-error flag.

Function
REQ-015 Internal frame buffer of K*K+K words of B bits; write pointer wcnt (0..K*K+K), read pointer rcnt.
REQ-016 A word is accepted on a cycle where s_valid and s_ready are both high; it is written at buffer[wcnt] and wcnt increments.
REQ-017 s_ready = (state is FILL or WAIT) and wcnt < K*K+K; combinational from registered state only, never from s_valid.
REQ-018 States: FILL, LD_M, GAP, LD_V, STRT, WAIT.
REQ-019 FILL -> LD_M when wcnt = K*K+K; loadMatrix is high for exactly the first LD_M cycle (cycle L).
REQ-020 LD_M: data_out = buffer[i] in cycle L+1+i, for i = 0..K*K-1, with no gaps.
REQ-021 GAP: in cycle L+1+K*K, loadVector is high for one cycle, then the FSM enters LD_V.
REQ-022 LD_V: data_out = buffer[K*K+j] in cycle L+2+K*K+j, for j = 0..K-1, with no gaps.
REQ-023 STRT: start is high for the single cycle after the last vector word; the FSM then enters WAIT, and wcnt clears to 0 in the same transition.
REQ-024 WAIT: the FSM holds until done = 1, then goes to LD_M if wcnt = K*K+K, else to FILL.
REQ-025 Filling the next frame is permitted during WAIT (overlap); the buffer is not re-read before done.
REQ-026 If done and acceptance of the final word of the next frame coincide, the FSM goes to LD_M on the next cycle.
REQ-027 data_out = 0 in every cycle not covered by REQ-020/REQ-022.
REQ-028 loadMatrix, loadVector and start are mutually exclusive, and each is high for at most one cycle per frame.
REQ-029 done received outside WAIT is ignored for sequencing and sets err = 1 until reset.
REQ-030 s_valid while s_ready = 0 is not an error; the word is held off upstream and not lost.

Reset
REQ-031 On reset low: state = FILL, wcnt = rcnt = 0, err = 0, loadMatrix = loadVector = start = 0, data_out = 0, busy = 0, with s_ready = 1 once released.
REQ-032 Reset asserted mid-frame, mid-load or in WAIT discards the partial frame; buffer contents need not be cleared.
REQ-033 After reset release, the first accepted word is frame word 0.

Verification (K=4, B=8)
REQ-034 Stream words 1..20 with s_valid held high -> accepted on 20 consecutive cycles; loadMatrix pulses once; data_out = 1..16 on the 16 following cycles; loadVector pulses; data_out = 17..20; start pulses; busy stays high until done.
REQ-035 Same frame with s_valid toggled every other cycle -> MVM-side timing is identical to REQ-034 (no gaps in data_out) once the frame is complete.
REQ-036 Feed the second frame (values -1..-20) during WAIT and pulse done 10 cycles after the final word -> loadMatrix occurs the cycle after done; data_out = -1..-16 and then -17..-20.
REQ-037 Pulse done while in FILL -> err = 1, no pulses issued, state unchanged.
REQ-038 Assert reset on the 8th LD_M word -> all outputs zero immediately; after release, 20 new words yield a normal frame.
REQ-039 Hold s_valid high through WAIT with 25 words available -> exactly 20 are accepted; s_ready stays low until the frame is streamed and the FSM is back in WAIT.

Source files
------------

// File: rtl/mvm_stream_loader.sv
// mvm_stream_loader
//   Gathers one frame from an upstream stream into a local buffer: K*K
//   matrix words (row-major), then K vector words. It then replays the frame
//   to a matrix-vector multiplier as a fixed pulse/data sequence:
//     loadMatrix, K*K matrix words, loadVector, K vector words, start.
//   It then waits for the multiplier's done pulse. The next frame may be
//   collected while waiting. If it is complete by the time done arrives, the
//   following replay begins on the very next cycle.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset      : asynchronous, active-low reset
//   s_data     : upstream word (signed, B bits)
//   s_valid    : upstream word valid
//   s_ready    : this block takes a word this cycle
//   loadMatrix : one-cycle pulse that opens matrix load in the multiplier
//   loadVector : one-cycle pulse that opens vector load in the multiplier
//   start      : one-cycle pulse that starts the multiplication
//   data_out   : word driven to the multiplier data input (0 when idle)
//   done       : multiplier completion pulse
//   busy       : high in every state except FILL
//   err        : sticky flag, set by a done pulse that arrives outside WAIT
//   state_dbg  : current FSM state (FILL=0 LD_M=1 GAP=2 LD_V=3 STRT=4 WAIT=5)
//
// Upstream handshake: a word moves on a rising edge where s_valid and s_ready
// are both high. s_ready depends only on registered state, so it never
// depends on s_valid. A word offered while s_ready is low stays with the
// sender. It is neither lost nor an error.

module mvm_stream_loader #(
  parameter int K = 4,
  parameter int B = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [B-1:0] s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic                loadMatrix,
  output logic                loadVector,
  output logic                start,
  output logic signed [B-1:0] data_out,
  input  logic                done,
  output logic                busy,
  output logic                err,
  output logic [2:0]          state_dbg
);

  localparam int KK = K * K;
  localparam int N  = KK + K;                    // words per frame
  localparam int PW = $clog2(N + 1);             // pointer width, holds 0..N
  localparam int IW = (N > 1) ? $clog2(N) : 1;   // buffer index width

  typedef enum logic [2:0] {
    S_FILL = 3'd0,
    S_LD_M = 3'd1,
    S_GAP  = 3'd2,
    S_LD_V = 3'd3,
    S_STRT = 3'd4,
    S_WAIT = 3'd5
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [PW-1:0]       wcnt;
  logic [PW-1:0]       rcnt;
  logic [PW-1:0]       rd_ptr;
  logic signed [B-1:0] buffer [N];
  logic                accept;
  logic                frame_full;

  assign accept = s_valid && s_ready;

  // The frame counts as complete when it already holds N words, or when the
  // last word is taken this cycle. This lets a done pulse that coincides with
  // the final word launch the next replay on the following cycle.
  assign frame_full = (wcnt == PW'(N)) || (accept && (wcnt == PW'(N - 1)));

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_FILL: if (frame_full) state_nxt = S_LD_M;
      S_LD_M: if (rcnt == PW'(KK)) state_nxt = S_GAP;
      S_GAP:  state_nxt = S_LD_V;
      S_LD_V: if (rcnt == PW'(N - 1)) state_nxt = S_STRT;
      S_STRT: state_nxt = S_WAIT;
      S_WAIT: if (done) state_nxt = frame_full ? S_LD_M : S_FILL;
      default: state_nxt = S_FILL;
    endcase
  end

  // ---------------------------------------------------------------- counters
  // In LD_M, rcnt counts cycles within the state. Cycle 0 carries the
  // loadMatrix pulse, and cycle c (c >= 1) carries matrix word c-1. In LD_V,
  // rcnt is the buffer address of the vector word being driven.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wcnt <= '0;
      rcnt <= '0;
    end else begin
      if (state == S_STRT) begin
        wcnt <= '0;
      end else if (accept) begin
        wcnt <= wcnt + PW'(1);
      end
      case (state)
        S_LD_M:  rcnt <= rcnt + PW'(1);
        S_GAP:   rcnt <= PW'(KK);
        S_LD_V:  rcnt <= rcnt + PW'(1);
        default: rcnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else if (done && (state != S_WAIT)) begin
      err <= 1'b1;
    end
  end

  // Buffer contents survive reset. The write pointer alone defines the frame.
  always_ff @(posedge clk) begin
    if (accept) begin
      buffer[wcnt[IW-1:0]] <= s_data;
    end
  end

  // ----------------------------------------------------------------- outputs
  always_comb begin
    rd_ptr     = (state == S_LD_M) ? (rcnt - PW'(1)) : rcnt;
    s_ready    = ((state == S_FILL) || (state == S_WAIT)) && (wcnt < PW'(N));
    loadMatrix = (state == S_LD_M) && (rcnt == '0);
    loadVector = (state == S_GAP);
    start      = (state == S_STRT);
    busy       = (state != S_FILL);
    state_dbg  = state;
    data_out   = '0;
    if (((state == S_LD_M) && (rcnt != '0)) || (state == S_LD_V)) begin
      data_out = buffer[rd_ptr[IW-1:0]];
    end
  end

endmodule

// File: tb/tb_mvm_stream_loader.sv
// Bench for mvm_stream_loader (K=4, B=8).
// Reference model: the words the loader has taken are collected as frames.
// Once a frame is complete and the multiplier side is free, the model
// schedules the whole multiplier-side cycle sequence for that frame in an
// expected queue, and compares it against the outputs one cycle at a time.
module tb_mvm_stream_loader;

  localparam int K  = 4;
  localparam int B  = 8;
  localparam int KK = K * K;
  localparam int N  = KK + K;
  localparam int TW = B + 3;   // {loadMatrix, loadVector, start, data_out}

  // ------------------------------------------------------- clock and reset
  logic                clk = 1'b0;
  logic                reset;
  logic signed [B-1:0] s_data;
  logic                s_valid;
  logic                s_ready;
  logic                loadMatrix;
  logic                loadVector;
  logic                start;
  logic signed [B-1:0] data_out;
  logic                done;
  logic                busy;
  logic                err;
  logic [2:0]          state_dbg;

  always #5 clk = ~clk;

  mvm_stream_loader #(.K(K), .B(B)) dut (
    .clk        (clk),
    .reset      (reset),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .loadMatrix (loadMatrix),
    .loadVector (loadVector),
    .start      (start),
    .data_out   (data_out),
    .done       (done),
    .busy       (busy),
    .err        (err),
    .state_dbg  (state_dbg)
  );

  // ----------------------------------------------------- model / scoreboard
  typedef enum {P_IDLE, P_STREAM, P_AWAIT} phase_t;

  int                  checks = 0;
  int                  failures = 0;
  phase_t              phase;
  logic signed [B-1:0] in_q[$];    // words of the frame being collected
  logic [TW-1:0]       exp_q[$];   // expected multiplier-side cycles
  logic signed [B-1:0] src_q[$];   // words still to be offered upstream
  logic                err_exp;
  int                  stream_pos;
  logic                last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    phase = P_IDLE;
    in_q.delete();
    exp_q.delete();
    err_exp = 1'b0;
    stream_pos = 0;
  endtask

  task automatic launch();
    exp_q.push_back({3'b100, {B{1'b0}}});
    for (int i = 0; i < KK; i++) exp_q.push_back({3'b000, in_q[i]});
    exp_q.push_back({3'b010, {B{1'b0}}});
    for (int i = KK; i < N; i++) exp_q.push_back({3'b000, in_q[i]});
    exp_q.push_back({3'b001, {B{1'b0}}});
    in_q.delete();
    phase = P_STREAM;
    stream_pos = 0;
  endtask

  // One clock cycle. Inputs are already driven, and outputs are sampled here
  // (1 time unit after the previous rising edge). The model then advances
  // and the task waits for the next edge.
  task automatic cycle();
    phase_t        cur;
    logic          rdy_exp;
    logic [TW-1:0] tup_obs;
    logic [TW-1:0] tup_exp;
    cur = phase;
    rdy_exp = ((cur == P_IDLE) || (cur == P_AWAIT)) && (in_q.size() < N);
    chk("s_ready", s_ready, rdy_exp);
    chk("busy", busy, cur != P_IDLE);
    chk("err", err, err_exp);
    tup_obs = {loadMatrix, loadVector, start, data_out};
    tup_exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    chk("mvm_side", tup_obs, tup_exp);
    last_acc = s_valid && rdy_exp;
    if (last_acc) in_q.push_back(s_data);
    if (cur == P_STREAM) begin
      stream_pos++;
      if (exp_q.size() == 0) phase = P_AWAIT;
    end
    if (done) begin
      if (cur == P_AWAIT) phase = P_IDLE;
      else err_exp = 1'b1;
    end
    if ((phase == P_IDLE) && (in_q.size() == N)) launch();
    @(posedge clk);
    #1;
  endtask

  // ------------------------------------------------------------ driver tasks
  task automatic push_frame(input int base, input int step);
    for (int i = 0; i < N; i++) src_q.push_back(B'(base + step * i));
  endtask

  // mode 0: valid held high, 1: valid toggles every cycle, 2: random valid
  task automatic run_src(input int mode, input int leave, input int max_cycles);
    int   n = 0;
    logic tog = 1'b1;
    while ((src_q.size() > leave) && (n < max_cycles)) begin
      s_valid = (mode == 0) ? 1'b1 : (mode == 1) ? tog : ($urandom_range(0, 3) != 0);
      s_data  = src_q[0];
      cycle();
      if (last_acc) void'(src_q.pop_front());
      tog = ~tog;
      n++;
    end
    s_valid = 1'b0;
    s_data  = '0;
    chk("src_drained", src_q.size(), leave);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic wait_await(input int max_cycles);
    int n = 0;
    while ((phase != P_AWAIT) && (n < max_cycles)) begin
      cycle();
      n++;
    end
    chk("reach_wait", phase == P_AWAIT, 1);
  endtask

  task automatic pulse_done();
    done = 1'b1;
    cycle();
    done = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------ directed run
  initial begin
    int n;
    int acc_cnt;
    reset   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    done    = 1'b0;
    model_reset();

    #1;
    chk("rst_loadMatrix", loadMatrix, 0);
    chk("rst_loadVector", loadVector, 0);
    chk("rst_start", start, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("rel_s_ready", s_ready, 1);

    // Frame 1..20 with valid held high.
    push_frame(1, 1);
    run_src(0, 0, 40);
    wait_await(40);
    idle(3);
    chk("busy_until_done", busy, 1);
    pulse_done();

    // Same-shaped frame with valid toggling every other cycle.
    push_frame(21, 1);
    run_src(1, 0, 80);
    wait_await(40);

    // Next frame (-1..-20) collected during WAIT, done 10 cycles after last word.
    push_frame(-1, -1);
    run_src(0, 0, 40);
    idle(9);
    pulse_done();
    chk("lm_after_done", loadMatrix, 1);
    wait_await(40);

    // Done coincides with the final word of the next frame.
    push_frame(50, 3);
    run_src(0, 1, 40);
    s_valid = 1'b1;
    s_data  = src_q[0];
    done    = 1'b1;
    cycle();
    if (last_acc) void'(src_q.pop_front());
    done    = 1'b0;
    s_valid = 1'b0;
    chk("coincide_accept", last_acc, 1);
    chk("lm_coincide", loadMatrix, 1);
    wait_await(40);
    pulse_done();

    // Done while filling is a protocol error, with no other effect.
    idle(2);
    pulse_done();
    idle(3);
    chk("err_sticky", err, 1);

    // Reset during the 8th matrix word of a frame.
    push_frame(7, 5);
    run_src(0, 0, 40);
    n = 0;
    while (!((phase == P_STREAM) && (stream_pos == 8)) && (n < 40)) begin
      cycle();
      n++;
    end
    chk("reach_ld_m8", stream_pos, 8);
    chk("ld_m_word8", data_out, 42);
    reset = 1'b0;
    #1;
    chk("midrst_loadMatrix", loadMatrix, 0);
    chk("midrst_loadVector", loadVector, 0);
    chk("midrst_start", start, 0);
    chk("midrst_data_out", data_out, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_err", err, 0);
    model_reset();
    src_q.delete();
    idle(2);
    reset = 1'b1;
    push_frame(100, 1);
    run_src(0, 0, 40);
    wait_await(40);
    pulse_done();

    // Valid held through WAIT with 25 words available.
    push_frame(-50, 2);
    run_src(0, 0, 40);
    wait_await(40);
    push_frame(60, -1);
    for (int i = 0; i < 5; i++) src_q.push_back(B'(-90 - i));
    acc_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      s_valid = 1'b1;
      s_data  = src_q[0];
      cycle();
      if (last_acc) begin
        void'(src_q.pop_front());
        acc_cnt++;
      end
    end
    chk("accepted_in_wait", acc_cnt, 20);
    chk("s_ready_full", s_ready, 0);
    s_valid = 1'b1;
    s_data  = src_q[0];
    pulse_done();
    run_src(0, 0, 80);
    pulse_done();

    // Random traffic: random data, valid, done timing and rare stray done.
    for (int i = 0; i < 700; i++) begin
      if (src_q.size() < 4) src_q.push_back(B'($urandom_range(0, 255)));
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = src_q[0];
      done    = ((phase == P_AWAIT) && ($urandom_range(0, 7) == 0)) ||
                ($urandom_range(0, 299) == 0);
      cycle();
      if (last_acc) void'(src_q.pop_front());
    end
    done    = 1'b0;
    s_valid = 1'b0;
    idle(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
